// File: rtl/audio_nios_cpu_mult_seq.sv
// Sequential 2*WIDTH-bit multiplier: one 16x16 partial product per cycle, start/done handshake.
// Optional signed high-half modes are built only when AUDIO_NIOS_MULT_SIGNED_EN is defined.
module audio_nios_cpu_mult_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             kill,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int N  = WIDTH / 16;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = 2 * WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic            busy_r, done_r, op_hi_r, neg_r;
   logic [WIDTH-1:0] result_r, a_mag_r, b_mag_r;
   logic [AW-1:0]   acc_r, term_s, fix_val_s;
   logic [CW-1:0]   i_r, j_r;
   logic            s1_s, s2_s, last_s;
   logic [WIDTH-1:0] a_mag_s, b_mag_s;
   logic [15:0]     a_dig_s, b_dig_s;
   logic [31:0]     pp_s;
   int              shamt_s;

   // Operand conditioning at the start edge: sign flags and magnitudes.
   always_comb begin
      s1_s    = 1'b0;
      s2_s    = 1'b0;
      a_mag_s = src1;
      b_mag_s = src2;
`ifdef AUDIO_NIOS_MULT_SIGNED_EN
      if (op[1]) begin
         s1_s = src1[WIDTH-1];
      end else begin
         s1_s = 1'b0;
      end
      if (op == 2'b11) begin
         s2_s = src2[WIDTH-1];
      end else begin
         s2_s = 1'b0;
      end
      if (s1_s) begin
         a_mag_s = -src1;
      end else begin
         a_mag_s = src1;
      end
      if (s2_s) begin
         b_mag_s = -src2;
      end else begin
         b_mag_s = src2;
      end
`endif
   end

   // Partial-product datapath and final sign fix-up.
   always_comb begin
      a_dig_s   = a_mag_r[16*i_r +: 16];
      b_dig_s   = b_mag_r[16*j_r +: 16];
      pp_s      = {16'd0, a_dig_s} * {16'd0, b_dig_s};
      shamt_s   = 16 * (int'(i_r) + int'(j_r));
      term_s    = AW'(pp_s) << shamt_s;
      last_s    = (i_r == CW'(N - 1)) && (j_r == CW'(N - 1));
      if (neg_r) begin
         fix_val_s = -acc_r;
      end else begin
         fix_val_s = acc_r;
      end
   end

   // Next-state logic; kill always wins and returns to IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (kill) begin
               state_s = ST_IDLE;
            end else if (start) begin
               state_s = ST_MUL;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (kill) begin
               state_s = ST_IDLE;
            end else if (last_s) begin
               state_s = ST_FIX;
            end else begin
               state_s = ST_MUL;
            end
         end
         ST_FIX:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State, datapath registers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
         op_hi_r  <= 1'b0;
         neg_r    <= 1'b0;
         a_mag_r  <= '0;
         b_mag_r  <= '0;
         acc_r    <= '0;
         i_r      <= '0;
         j_r      <= '0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != ST_IDLE);
         done_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (!kill && start) begin
                  op_hi_r <= (op != 2'b00);
                  neg_r   <= s1_s ^ s2_s;
                  a_mag_r <= a_mag_s;
                  b_mag_r <= b_mag_s;
                  acc_r   <= '0;
                  i_r     <= '0;
                  j_r     <= '0;
               end
            end
            ST_MUL: begin
               if (!kill) begin
                  acc_r <= acc_r + term_s;
                  if (j_r == CW'(N - 1)) begin
                     j_r <= '0;
                     i_r <= i_r + 1'b1;
                  end else begin
                     j_r <= j_r + 1'b1;
                  end
               end
            end
            ST_FIX: begin
               if (!kill) begin
                  result_r <= op_hi_r ? fix_val_s[AW-1:WIDTH] : fix_val_s[WIDTH-1:0];
                  done_r   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;

endmodule

// File: tb/tb_audio_nios_cpu_mult_seq.sv
// Self-checking bench for audio_nios_cpu_mult_seq at WIDTH 16, 32 and 64 against a wide-arithmetic model.
// Honors AUDIO_NIOS_MULT_SIGNED_EN to pick signed or unsigned expectations.
module tb_audio_nios_cpu_mult_seq;

   logic        clk = 1'b0;
   logic        reset, kill;
   logic [1:0]  op;
   logic [63:0] src1, src2;
   logic        start16, start32, start64;
   logic        busy16, busy32, busy64;
   logic        done16, done32, done64;
   logic [15:0] res16;
   logic [31:0] res32;
   logic [63:0] res64;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   audio_nios_cpu_mult_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .kill(kill), .op(op),
      .src1(src1[15:0]), .src2(src2[15:0]), .busy(busy16), .done(done16), .result(res16));
   audio_nios_cpu_mult_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .start(start32), .kill(kill), .op(op),
      .src1(src1[31:0]), .src2(src2[31:0]), .busy(busy32), .done(done32), .result(res32));
   audio_nios_cpu_mult_seq #(.WIDTH(64)) dut64 (
      .clk(clk), .reset(reset), .start(start64), .kill(kill), .op(op),
      .src1(src1), .src2(src2), .busy(busy64), .done(done64), .result(res64));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: exact integer product of the interpreted operands, then half selection.
   function automatic logic [63:0] ref_mul(input int w, input logic [1:0] o,
                                           input logic [63:0] a, input logic [63:0] b);
      logic signed [129:0] x, y, p;
      logic [63:0] mask;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      a = a & mask;
      b = b & mask;
      x = $signed({66'd0, a});
      y = $signed({66'd0, b});
`ifdef AUDIO_NIOS_MULT_SIGNED_EN
      if (o[1] && a[w-1]) x = x - (130'sd1 <<< w);
      if (o == 2'b11 && b[w-1]) y = y - (130'sd1 <<< w);
`endif
      p = x * y;
      if (o == 2'b00) return 64'(p) & mask;
      return 64'(p >>> w) & mask;
   endfunction

   function automatic logic sel_done(input int w);
      return (w == 16) ? done16 : (w == 32) ? done32 : done64;
   endfunction
   function automatic logic sel_busy(input int w);
      return (w == 16) ? busy16 : (w == 32) ? busy32 : busy64;
   endfunction
   function automatic logic [63:0] sel_res(input int w);
      return (w == 16) ? {48'd0, res16} : (w == 32) ? {32'd0, res32} : res64;
   endfunction
   task automatic set_start(input int w, input logic v);
      if (w == 16) start16 = v;
      else if (w == 32) start32 = v;
      else start64 = v;
   endtask

   // One transaction; inputs are scrambled right after the start edge.
   task automatic run(input int w, input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                      output logic [63:0] res, output int lat, output int busy_low,
                      output logic busy_at_done);
      @(negedge clk);
      op = o; src1 = a; src2 = b;
      set_start(w, 1'b1);
      @(negedge clk);
      set_start(w, 1'b0);
      op = 2'($urandom); src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
      lat = 1; busy_low = 0;
      while (!sel_done(w) && lat < 64) begin
         if (!sel_busy(w)) busy_low++;
         @(negedge clk);
         lat++;
      end
      res = sel_res(w);
      busy_at_done = sel_busy(w);
   endtask

   initial begin
      logic [63:0] r, prior, a, b;
      int lat, bl, c, nd, last, bad, w;
      logic bd;
      logic [1:0] o;

      reset = 1'b1; kill = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
      start16 = 1'b0; start32 = 1'b0; start64 = 1'b0;
      repeat (2) @(negedge clk);
      check("reset16", {62'd0, busy16, done16} | {48'd0, res16}, 64'd0);
      check("reset32", {62'd0, busy32, done32} | {32'd0, res32}, 64'd0);
      check("reset64", {62'd0, busy64, done64} | res64, 64'd0);
      reset = 1'b0;

      run(32, 2'b00, 64'h0001_0003, 64'h0002_0005, r, lat, bl, bd);
      check("mul_lo", r, 64'h000B_000F);
      check("lat32", lat, 6);
      check("busy_during", bl, 0);
      check("busy_at_done", {63'd0, bd}, 64'd0);
      run(32, 2'b01, 64'h0001_0003, 64'h0002_0005, r, lat, bl, bd);
      check("mulxuu_small", r, 64'h0000_0002);
      run(32, 2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF, r, lat, bl, bd);
      check("mulxuu_ones", r, 64'hFFFF_FFFE);
      run(32, 2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, r, lat, bl, bd);
      check("mul_ones", r, 64'h0000_0001);
`ifdef AUDIO_NIOS_MULT_SIGNED_EN
      run(32, 2'b11, 64'hFFFF_FFFF, 64'hFFFF_FFFF, r, lat, bl, bd);
      check("mulxss_m1", r, 64'h0000_0000);
      run(32, 2'b11, 64'h8000_0000, 64'h8000_0000, r, lat, bl, bd);
      check("mulxss_min", r, 64'h4000_0000);
      run(32, 2'b10, 64'hFFFF_FFFF, 64'h0000_0002, r, lat, bl, bd);
      check("mulxsu", r, 64'hFFFF_FFFF);
`else
      run(32, 2'b11, 64'hFFFF_FFFF, 64'hFFFF_FFFF, r, lat, bl, bd);
      check("mulxss_uns", r, 64'hFFFF_FFFE);
      run(32, 2'b10, 64'hFFFF_FFFF, 64'h0000_0002, r, lat, bl, bd);
      check("mulxsu_uns", r, 64'h0000_0001);
`endif

      // Back-to-back: start held high.
      @(negedge clk);
      op = 2'b01; src1 = 64'h1234_5678; src2 = 64'h9ABC_DEF0; start32 = 1'b1;
      c = 0; nd = 0; last = 0; bad = 0;
      repeat (19) begin
         @(negedge clk);
         c++;
         if (done32) begin
            check(nd == 0 ? "b2b_first" : "b2b_period", c - last, 6);
            check("b2b_res", {32'd0, res32}, ref_mul(32, 2'b01, 64'h1234_5678, 64'h9ABC_DEF0));
            last = c;
            nd++;
         end else if (!busy32) begin
            bad++;
         end
      end
      start32 = 1'b0;
      check("b2b_count", nd, 3);
      check("b2b_busy", bad, 0);
      repeat (8) @(negedge clk);

      // Start pulsed while busy is ignored.
      op = 2'b00; src1 = 64'h0000_1234; src2 = 64'h0000_0100; start32 = 1'b1;
      @(negedge clk); start32 = 1'b0;
      @(negedge clk); src1 = 64'h5555; src2 = 64'h7777; start32 = 1'b1;
      @(negedge clk); start32 = 1'b0;
      c = 3;
      while (!done32 && c < 40) begin @(negedge clk); c++; end
      check("ignore_lat", c, 6);
      check("ignore_res", {32'd0, res32}, 64'h0012_3400);
      nd = 0;
      repeat (10) begin @(negedge clk); if (done32) nd++; end
      check("ignore_nodone", nd, 0);
      prior = 64'h0012_3400;

      // Kill at cycle 3.
      op = 2'b01; src1 = 64'hDEAD_BEEF; src2 = 64'hCAFE_F00D; start32 = 1'b1;
      @(negedge clk); start32 = 1'b0;
      @(negedge clk);
      @(negedge clk); kill = 1'b1;
      @(negedge clk); kill = 1'b0;
      check("kill_busy", {63'd0, busy32}, 64'd0);
      nd = 0;
      repeat (8) begin @(negedge clk); if (done32) nd++; end
      check("kill_nodone", nd, 0);
      check("kill_result", {32'd0, res32}, prior);

      // Kill in IDLE drops a simultaneous start.
      kill = 1'b1; start32 = 1'b1;
      @(negedge clk); kill = 1'b0; start32 = 1'b0;
      check("kill_idle_busy", {63'd0, busy32}, 64'd0);
      nd = 0;
      repeat (8) begin @(negedge clk); if (done32) nd++; end
      check("kill_idle_nodone", nd, 0);

      // Reset mid-operation.
      op = 2'b00; src1 = 64'h0000_0007; src2 = 64'h0000_0009; start32 = 1'b1;
      @(negedge clk); start32 = 1'b0;
      @(negedge clk); reset = 1'b1;
      #1;
      check("reset_mid", {62'd0, busy32, done32} | {32'd0, res32}, 64'd0);
      @(negedge clk); reset = 1'b0;
      run(32, 2'b00, 64'h0000_0007, 64'h0000_0009, r, lat, bl, bd);
      check("after_reset", r, 64'd63);
      check("after_reset_lat", lat, 6);

      // Randomized sweep over all widths.
      for (int k = 0; k < 600; k++) begin
         w = (k < 200) ? 16 : (k < 400) ? 32 : 64;
         o = 2'($urandom);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: a = '0;
            1: a = {64{1'b1}};
            2: a = 64'd1 << (w - 1);
            default: ;
         endcase
         case ($urandom_range(0, 5))
            0: b = {64{1'b1}};
            1: b = 64'd1 << (w - 1);
            default: ;
         endcase
         run(w, o, a, b, r, lat, bl, bd);
         check($sformatf("rand%0d_op%0d", w, o), r, ref_mul(w, o, a, b));
         check($sformatf("rand%0d_lat", w), lat, (w / 16) * (w / 16) + 2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
